// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit and its store buffer.
package lsu_pkg;

   localparam int unsigned SbDepthDefault = 2;
   localparam logic [31:0] WordAlignMask  = 32'h0000_0003;

   typedef enum logic [1:0] {
      StIdle,
      StRdIssue,
      StRdWait
   } lsu_state_e;

   function automatic logic is_aligned(input logic [31:0] addr);
      return (addr & WordAlignMask) == 32'h0;
   endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// CPU request/response and Data_Memory signals of the load/store unit.
interface load_store_unit_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        MemWrite;
   logic        MemRead;
   logic [31:0] write_address;
   logic [31:0] read_address;
   logic [31:0] Write_data;
   logic [31:0] MemData_in;
   logic        mem_stall;
   logic        idle;

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, MemData_in, mem_stall,
      output req_ready, resp_valid, resp_rdata, resp_err, MemWrite, MemRead,
             write_address, read_address, Write_data, idle
   );

   modport master (
      output req_valid, req_write, req_addr, req_wdata, MemData_in, mem_stall,
      input  req_ready, resp_valid, resp_rdata, resp_err, MemWrite, MemRead,
             write_address, read_address, Write_data, idle
   );

endinterface

// File: rtl/load_store_unit_store_buffer.sv
// Store FIFO with youngest-match load forwarding over the current contents.
module store_buffer
   import lsu_pkg::*;
#(
   parameter int unsigned Depth = SbDepthDefault
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        push_i,
   input  logic [31:0] push_addr_i,
   input  logic [31:0] push_data_i,
   input  logic        pop_i,
   input  logic [31:0] lookup_addr_i,
   output logic        empty_o,
   output logic        full_o,
   output logic [31:0] head_addr_o,
   output logic [31:0] head_data_o,
   output logic        hit_o,
   output logic [31:0] hit_data_o
);

   localparam int unsigned PtrW = $clog2(Depth);

   logic [Depth-1:0][31:0] addr_q, addr_d, data_q, data_d;
   logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PtrW:0]          count_q, count_d;
   logic [PtrW-1:0]        idx;

   always_comb begin
      addr_d   = addr_q;
      data_d   = data_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_i) begin
         addr_d[wr_ptr_q] = push_addr_i;
         data_d[wr_ptr_q] = push_data_i;
         wr_ptr_d         = wr_ptr_q + 1'b1;
      end
      if (pop_i) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + {{PtrW{1'b0}}, push_i} - {{PtrW{1'b0}}, pop_i};
   end

   // Walk oldest to youngest so the last match wins.
   always_comb begin
      hit_o      = 1'b0;
      hit_data_o = '0;
      idx        = '0;
      for (int unsigned i = 0; i < Depth; i++) begin
         idx = rd_ptr_q + PtrW'(i);
         if (((PtrW + 1)'(i) < count_q) && (addr_q[idx] == lookup_addr_i)) begin
            hit_o      = 1'b1;
            hit_data_o = data_q[idx];
         end
      end
   end

   assign empty_o     = (count_q == '0);
   assign full_o      = (count_q == (PtrW + 1)'(Depth));
   assign head_addr_o = addr_q[rd_ptr_q];
   assign head_data_o = data_q[rd_ptr_q];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         addr_q   <= '0;
         data_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         addr_q   <= addr_d;
         data_q   <= data_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: buffered posted stores, forwarded or memory-read loads.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned SB_DEPTH = SbDepthDefault
) (
   input  logic              clk,
   input  logic              reset,
   load_store_unit_if.slave  bus
);

   lsu_state_e  state_q, state_d;
   logic        resp_valid_q, resp_valid_d;
   logic        resp_err_q, resp_err_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;
   logic [31:0] ld_addr_q, ld_addr_d;

   logic        sb_empty, sb_full, sb_hit;
   logic [31:0] sb_head_addr, sb_head_data, sb_hit_data;
   logic        accept, aligned, push, mem_read, mem_write;

   store_buffer #(
      .Depth (SB_DEPTH)
   ) u_store_buffer (
      .clk_i         (clk),
      .rst_ni        (reset),
      .push_i        (push),
      .push_addr_i   (bus.req_addr),
      .push_data_i   (bus.req_wdata),
      .pop_i         (mem_write),
      .lookup_addr_i (bus.req_addr),
      .empty_o       (sb_empty),
      .full_o        (sb_full),
      .head_addr_o   (sb_head_addr),
      .head_data_o   (sb_head_data),
      .hit_o         (sb_hit),
      .hit_data_o    (sb_hit_data)
   );

   // reset gates ready so nothing is accepted while the unit is held in reset.
   always_comb begin
      bus.req_ready = reset && (state_q == StIdle) && !sb_full;
      accept        = bus.req_valid && bus.req_ready;
      aligned       = is_aligned(bus.req_addr);
      push          = accept && aligned && bus.req_write;
      mem_read      = (state_q == StRdIssue) && !bus.mem_stall;
      mem_write     = !sb_empty && !bus.mem_stall && !mem_read;
   end

   always_comb begin
      bus.MemRead       = mem_read;
      bus.read_address  = mem_read ? ld_addr_q : '0;
      bus.MemWrite      = mem_write;
      bus.write_address = mem_write ? sb_head_addr : '0;
      bus.Write_data    = mem_write ? sb_head_data : '0;
      bus.resp_valid    = resp_valid_q;
      bus.resp_rdata    = resp_rdata_q;
      bus.resp_err      = resp_err_q;
      bus.idle          = sb_empty && (state_q == StIdle);
   end

   always_comb begin
      state_d      = state_q;
      ld_addr_d    = ld_addr_q;
      resp_valid_d = 1'b0;
      resp_err_d   = 1'b0;
      resp_rdata_d = '0;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               if (!aligned) begin
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
               end else if (bus.req_write) begin
                  resp_valid_d = 1'b1;
               end else if (sb_hit) begin
                  resp_valid_d = 1'b1;
                  resp_rdata_d = sb_hit_data;
               end else begin
                  state_d   = StRdIssue;
                  ld_addr_d = bus.req_addr;
               end
            end
         end
         StRdIssue: begin
            if (mem_read) state_d = StRdWait;
         end
         StRdWait: begin
            state_d      = StIdle;
            resp_valid_d = 1'b1;
            resp_rdata_d = bus.MemData_in;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= StIdle;
         ld_addr_q    <= '0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= '0;
      end else begin
         state_q      <= state_d;
         ld_addr_q    <= ld_addr_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_rdata_q <= resp_rdata_d;
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a response scoreboard.
module tb_load_store_unit;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } resp_t;

   logic  clk = 1'b0;
   logic  rst_n = 1'b0;
   int    n_cmp = 0;
   int    n_fail = 0;
   resp_t sb_q[$];
   resp_t got;

   load_store_unit_if bus ();

   load_store_unit #(
      .SB_DEPTH (2)
   ) dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic drive(input logic wr, input logic [31:0] addr, input logic [31:0] data);
      bus.req_valid = 1'b1;
      bus.req_write = wr;
      bus.req_addr  = addr;
      bus.req_wdata = data;
   endtask

   task automatic expect_resp(input logic [31:0] rdata, input logic err);
      resp_t r;
      r.rdata = rdata;
      r.err   = err;
      sb_q.push_back(r);
   endtask

   // Response monitor plus the read/write exclusivity invariant.
   always @(negedge clk) begin
      if (rst_n) begin
         check("rd_wr_exclusive", 32'(bus.MemRead && bus.MemWrite), 32'h0);
         if (bus.resp_valid) begin
            check("resp_expected", 32'(sb_q.size() != 0), 32'h1);
            if (sb_q.size() != 0) begin
               got = sb_q.pop_front();
               check("resp_rdata", bus.resp_rdata, got.rdata);
               check("resp_err", 32'(bus.resp_err), 32'(got.err));
            end
         end
      end else begin
         check("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
      end
   end

   initial begin
      bus.req_valid  = 1'b0;
      bus.req_write  = 1'b0;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;
      bus.MemData_in = '0;
      bus.mem_stall  = 1'b0;

      // Reset values, then release.
      smp();
      check("rst_req_ready", 32'(bus.req_ready), 32'h0);
      check("rst_memwrite", 32'(bus.MemWrite), 32'h0);
      check("rst_memread", 32'(bus.MemRead), 32'h0);
      check("rst_resp_rdata", bus.resp_rdata, 32'h0);
      tick();
      rst_n = 1'b1;
      smp();
      check("rel_req_ready", 32'(bus.req_ready), 32'h1);
      check("rel_idle", 32'(bus.idle), 32'h1);

      // Store 0xFFFFFFFF to 12.
      tick();
      drive(1'b1, 32'd12, 32'hFFFF_FFFF);
      smp();
      check("st_ready", 32'(bus.req_ready), 32'h1);
      expect_resp(32'h0, 1'b0);
      tick();
      bus.req_valid = 1'b0;
      smp();
      check("st_memwrite", 32'(bus.MemWrite), 32'h1);
      check("st_waddr", bus.write_address, 32'd12);
      check("st_wdata", bus.Write_data, 32'hFFFF_FFFF);
      check("st_resp_valid", 32'(bus.resp_valid), 32'h1);
      tick();
      smp();
      check("st_idle", 32'(bus.idle), 32'h1);
      check("st_waddr_zero", bus.write_address, 32'h0);

      // Load 12 from memory, then a misaligned load on the response cycle.
      tick();
      drive(1'b0, 32'd12, 32'h0);
      smp();
      expect_resp(32'hDEAD_BEEF, 1'b0);
      tick();
      bus.req_valid = 1'b0;
      smp();
      check("ld_memread", 32'(bus.MemRead), 32'h1);
      check("ld_raddr", bus.read_address, 32'd12);
      check("ld_busy_ready", 32'(bus.req_ready), 32'h0);
      tick();
      bus.MemData_in = 32'hDEAD_BEEF;
      smp();
      check("ld_wait_memread", 32'(bus.MemRead), 32'h0);
      check("ld_wait_raddr", bus.read_address, 32'h0);
      tick();
      bus.MemData_in = 32'h0;
      drive(1'b0, 32'd6, 32'h0);
      smp();
      check("ld_resp_valid", 32'(bus.resp_valid), 32'h1);
      check("ld_resp_ready", 32'(bus.req_ready), 32'h1);
      expect_resp(32'h0, 1'b1);
      tick();
      bus.req_valid = 1'b0;
      smp();
      check("mis_resp_err", 32'(bus.resp_err), 32'h1);
      check("mis_memread", 32'(bus.MemRead), 32'h0);
      check("mis_memwrite", 32'(bus.MemWrite), 32'h0);
      check("mis_idle", 32'(bus.idle), 32'h1);

      // Stalled stores fill the buffer, then drain in order.
      tick();
      bus.mem_stall = 1'b1;
      drive(1'b1, 32'd8, 32'h11);
      smp();
      expect_resp(32'h0, 1'b0);
      tick();
      drive(1'b1, 32'd8, 32'h22);
      smp();
      check("fill_ready", 32'(bus.req_ready), 32'h1);
      expect_resp(32'h0, 1'b0);
      tick();
      bus.req_valid = 1'b0;
      smp();
      check("full_ready", 32'(bus.req_ready), 32'h0);
      check("stall_memwrite", 32'(bus.MemWrite), 32'h0);
      tick();
      bus.mem_stall = 1'b0;
      smp();
      check("drain0_wdata", bus.Write_data, 32'h11);
      check("drain0_waddr", bus.write_address, 32'd8);
      tick();
      smp();
      check("drain1_wdata", bus.Write_data, 32'h22);
      tick();
      smp();
      check("drain_idle", 32'(bus.idle), 32'h1);

      // Forwarding from buffer, including from the entry popping this edge.
      tick();
      bus.mem_stall = 1'b1;
      drive(1'b1, 32'd8, 32'h11);
      smp();
      expect_resp(32'h0, 1'b0);
      tick();
      drive(1'b0, 32'd8, 32'h0);
      smp();
      check("fwd_ready", 32'(bus.req_ready), 32'h1);
      expect_resp(32'h11, 1'b0);
      tick();
      bus.req_valid = 1'b0;
      smp();
      check("fwd_no_memread", 32'(bus.MemRead), 32'h0);
      check("fwd_resp_rdata", bus.resp_rdata, 32'h11);
      tick();
      drive(1'b1, 32'd8, 32'h55);
      smp();
      expect_resp(32'h0, 1'b0);
      tick();
      bus.req_valid = 1'b0;
      bus.mem_stall = 1'b0;
      smp();
      check("fwd_full_ready", 32'(bus.req_ready), 32'h0);
      check("fwd_drain_a", bus.Write_data, 32'h11);
      tick();
      drive(1'b0, 32'd8, 32'h0);
      smp();
      check("fwd_pop_ready", 32'(bus.req_ready), 32'h1);
      check("fwd_drain_b", bus.Write_data, 32'h55);
      expect_resp(32'h55, 1'b0);
      tick();
      bus.req_valid = 1'b0;
      smp();
      check("fwd2_no_memread", 32'(bus.MemRead), 32'h0);
      check("fwd2_idle", 32'(bus.idle), 32'h1);

      // Load issue takes priority over a pending drain.
      tick();
      bus.mem_stall = 1'b1;
      drive(1'b1, 32'd20, 32'h66);
      smp();
      expect_resp(32'h0, 1'b0);
      tick();
      drive(1'b0, 32'd24, 32'h0);
      smp();
      expect_resp(32'hCAFE_0001, 1'b0);
      tick();
      bus.req_valid = 1'b0;
      smp();
      check("issue_stall_memread", 32'(bus.MemRead), 32'h0);
      check("issue_stall_raddr", bus.read_address, 32'h0);
      tick();
      bus.mem_stall = 1'b0;
      smp();
      check("prio_memread", 32'(bus.MemRead), 32'h1);
      check("prio_raddr", bus.read_address, 32'd24);
      check("prio_memwrite", 32'(bus.MemWrite), 32'h0);
      tick();
      bus.MemData_in = 32'hCAFE_0001;
      smp();
      check("wait_drain_memwrite", 32'(bus.MemWrite), 32'h1);
      check("wait_drain_waddr", bus.write_address, 32'd20);
      check("wait_drain_wdata", bus.Write_data, 32'h66);
      tick();
      bus.MemData_in = 32'h0;
      smp();
      check("prio_idle", 32'(bus.idle), 32'h1);

      // Reset during RD_WAIT abandons the load.
      tick();
      drive(1'b0, 32'd40, 32'h0);
      smp();
      tick();
      bus.req_valid = 1'b0;
      smp();
      check("rw_memread", 32'(bus.MemRead), 32'h1);
      tick();
      bus.MemData_in = 32'h1234_5678;
      #1;
      rst_n = 1'b0;
      #1;
      check("arst_resp_valid", 32'(bus.resp_valid), 32'h0);
      check("arst_memread", 32'(bus.MemRead), 32'h0);
      check("arst_raddr", bus.read_address, 32'h0);
      check("arst_req_ready", 32'(bus.req_ready), 32'h0);
      smp();
      tick();
      bus.MemData_in = 32'h0;
      rst_n = 1'b1;
      smp();
      check("arel_req_ready", 32'(bus.req_ready), 32'h1);
      check("arel_idle", 32'(bus.idle), 32'h1);
      for (int i = 0; i < 4; i++) begin
         tick();
      end
      smp();
      check("sb_drained", 32'(sb_q.size()), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter SB_DEPTH, default 2, meaning store-buffer entry count (power of 2, >=2).
REQ-002 SHALL have clk  in  1  system clock, all state on rising edge.
REQ-003 SHALL have reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have req_valid  in  1  CPU request present.
REQ-005 SHALL have req_ready  out  1  unit accepts request this cycle.
REQ-006 SHALL have req_write  in  1  1=store, 0=load.
REQ-007 SHALL have req_addr  in  32  byte address, word aligned.
REQ-008 SHALL have req_wdata  in  32  store data.
REQ-009 SHALL have resp_valid  out  1  one-cycle response pulse.
REQ-010 SHALL have resp_rdata  out  32  load data, 0 for stores and errors.
REQ-011 SHALL have resp_err  out  1  misaligned request flag.
REQ-012 SHALL have MemWrite, MemRead  out  1 each  Data_Memory strobes.
REQ-013 SHALL have write_address, read_address, Write_data  out  32 each  Data_Memory address and data.
REQ-014 SHALL have MemData_in  in  32  Data_Memory read data, valid the cycle after MemRead is high.
REQ-015 SHALL have mem_stall  in  1  memory unavailable this cycle.
REQ-016 SHALL have idle  out  1  store buffer empty and FSM in IDLE.

Function
REQ-017 SHALL accept a request on a rising edge where req_valid and req_ready are both 1.
REQ-018 SHALL drive req_ready = (state==IDLE) and store buffer not full, independent of req_valid.
REQ-019 SHALL, for an accepted request with req_addr[1:0]!=0, take no memory action and pulse resp_valid with resp_err=1, resp_rdata=0 in the next cycle.
REQ-020 SHALL push an aligned accepted store into the store-buffer tail and pulse resp_valid (resp_err=0, resp_rdata=0) in the next cycle.
REQ-021 SHALL drain the buffer head in FIFO order: MemWrite=1, write_address/Write_data=head in any cycle with buffer non-empty, mem_stall=0 and MemRead=0, popping at that edge.
REQ-022 SHALL, for an aligned load matching any valid buffer entry (pre-edge contents, including an entry popping at the same edge), return the youngest matching data with resp_valid in the next cycle and no MemRead.
REQ-023 SHALL, for an aligned non-matching load, go IDLE->RD_ISSUE; in RD_ISSUE assert MemRead=1 and read_address=load address when mem_stall=0, else hold with MemRead=0.
REQ-024 SHALL go RD_ISSUE->RD_WAIT on an edge where MemRead=1, capture MemData_in at the end of RD_WAIT, return to IDLE and present it with resp_valid=1 in the following cycle (unstalled latency: 3 cycles from acceptance edge).
REQ-025 SHALL never assert MemRead and MemWrite together; a load issue has priority over a drain.
REQ-026 SHALL drive write_address/Write_data to 0 when MemWrite=0, and read_address to 0 when MemRead=0.
REQ-027 SHALL accept a new request in the same cycle resp_valid is high when req_ready permits.
REQ-028 SHALL hold req_ready=0 when the buffer is full, even for loads.

Reset
REQ-029 SHALL, while reset=0, asynchronously force state=IDLE, buffer empty, resp_valid=0, resp_rdata=0, resp_err=0, MemRead=MemWrite=0, all addresses/data 0, req_ready=0.
REQ-030 SHALL abandon any in-flight load and discard buffered stores on reset, with no response issued.
REQ-031 SHALL drive req_ready=1 and idle=1 in the first cycle after reset release.

Structure
REQ-032 SHALL place the FSM state enum (IDLE, RD_ISSUE, RD_WAIT), SB_DEPTH default and the word-alignment mask in a shared package, lsu_pkg.
REQ-033 SHALL implement the store FIFO with youngest-match forwarding as one sub-module, store_buffer.

Verification
REQ-034 SHALL test: store 0xFFFFFFFF to addr 12 -> resp_valid next cycle, MemWrite=1 with write_address=12, Write_data=0xFFFFFFFF the cycle after acceptance, then idle=1.
REQ-035 SHALL test: load addr 12, empty buffer, MemData_in=0xDEADBEEF -> MemRead=1, read_address=12 at N+1, resp_rdata=0xDEADBEEF at N+3.
REQ-036 SHALL test: mem_stall=1, stores addr 8 data 0x11 then 0x22 -> req_ready=0; release mem_stall -> writes 0x11 then 0x22 in order.
REQ-037 SHALL test: mem_stall=1, stores addr 8 data 0x11, load addr 8 -> resp_rdata=0x11 next cycle, MemRead never high.
REQ-038 SHALL test: load addr 6 -> resp_err=1, resp_rdata=0, no MemRead/MemWrite.
REQ-039 SHALL test: reset=0 during RD_WAIT -> all outputs 0 immediately, no resp_valid, req_ready=1 first cycle after release.
